// File: rtl/ras_commit_stack_if.sv
// Commit-side RAS bus: retire-stage update, return check, and restore stream toward
// the speculative fetch RAS. The stack is the slave; retire/fetch logic is the master.
interface ras_commit_stack_if #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 31
);
  localparam int CW = $clog2(SIZE) + 1;

  logic             s_commit_i;
  logic             s_push_i;
  logic             s_pop_i;
  logic [WIDTH-1:0] s_link_addr_i;
  logic [WIDTH-1:0] s_target_i;
  logic             s_predicted_i;
  logic [WIDTH-1:0] s_pred_addr_i;
  logic             s_mispredict_o;
  logic             s_restore_i;
  logic             s_rst_valid_o;
  logic             s_rst_ready_i;
  logic [WIDTH-1:0] s_rst_data_o;
  logic             s_rst_last_o;
  logic             s_rst_done_o;
  logic             s_busy_o;
  logic [CW-1:0]    s_depth_o;

  modport master (
    output s_commit_i, s_push_i, s_pop_i, s_link_addr_i, s_target_i,
           s_predicted_i, s_pred_addr_i, s_restore_i, s_rst_ready_i,
    input  s_mispredict_o, s_rst_valid_o, s_rst_data_o, s_rst_last_o,
           s_rst_done_o, s_busy_o, s_depth_o
  );

  modport slave (
    input  s_commit_i, s_push_i, s_pop_i, s_link_addr_i, s_target_i,
           s_predicted_i, s_pred_addr_i, s_restore_i, s_rst_ready_i,
    output s_mispredict_o, s_rst_valid_o, s_rst_data_o, s_rst_last_o,
           s_rst_done_o, s_busy_o, s_depth_o
  );
endinterface

// File: rtl/ras_commit_stack.sv
// Architectural return address stack updated at commit; checks predicted return
// targets and streams its contents oldest-first to rebuild the fetch RAS after a flush.
module ras_commit_stack #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 31
) (
  input  logic              s_clk_i,
  input  logic              s_reset_i,
  ras_commit_stack_if.slave bus
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE);

  typedef enum logic {ST_IDLE, ST_STREAM} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_mem [SIZE];
  logic [AW-1:0]    r_tp;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_idx;
  logic [CW-1:0]    r_rem;
  logic             r_mispredict;
  logic             r_done;

  logic             w_commit;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_tp_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [AW-1:0]    w_start;
  logic             w_handshake;

  // Commit is locked out while streaming so the restore pass sees a frozen stack.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_commit  = bus.s_commit_i && (r_state == ST_IDLE);
    w_tp_nxt  = r_tp;
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_tp;
    if (w_commit) begin
      if (bus.s_push_i && (!bus.s_pop_i || r_cnt == '0)) begin
        w_tp_nxt  = r_tp + PTR_ONE;
        w_waddr   = w_tp_nxt;
        w_we      = 1'b1;
        w_cnt_nxt = (r_cnt == CNT_FULL) ? CNT_FULL : r_cnt + CNT_ONE;
      end else if (bus.s_push_i) begin
        w_we = 1'b1;
      end else if (bus.s_pop_i && r_cnt != '0) begin
        w_tp_nxt  = r_tp - PTR_ONE;
        w_cnt_nxt = r_cnt - CNT_ONE;
      end
    end
  end

  // Oldest entry; at full depth the count's low bits wrap to 0, giving tp+1.
  assign w_start     = w_tp_nxt - w_cnt_nxt[AW-1:0] + PTR_ONE;
  assign w_handshake = (r_state == ST_STREAM) && bus.s_rst_ready_i;

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge s_clk_i) begin
    if (w_we && !s_reset_i) begin
      r_mem[w_waddr] <= bus.s_link_addr_i;
    end
  end

  always_ff @(posedge s_clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (s_reset_i) begin
      r_state      <= ST_IDLE;
      r_tp         <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_rem        <= '0;
      r_mispredict <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mispredict <= bus.s_commit_i && bus.s_pop_i && bus.s_predicted_i &&
                      (bus.s_pred_addr_i != bus.s_target_i);
      r_done       <= 1'b0;
      r_tp         <= w_tp_nxt;
      r_cnt        <= w_cnt_nxt;
      case (r_state)
        ST_IDLE: begin
          if (bus.s_restore_i) begin
            if (w_cnt_nxt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_STREAM;
              r_idx   <= w_start;
              r_rem   <= w_cnt_nxt;
            end
          end
        end
        ST_STREAM: begin
          if (bus.s_restore_i) begin
            r_idx <= w_start;
            r_rem <= r_cnt;
          end else if (w_handshake) begin
            if (r_rem == CNT_ONE) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
            r_idx <= r_idx + PTR_ONE;
            r_rem <= r_rem - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_mispredict_o = r_mispredict;
  assign bus.s_rst_valid_o  = (r_state == ST_STREAM);
  assign bus.s_busy_o       = (r_state == ST_STREAM);
  assign bus.s_rst_data_o   = (r_state == ST_STREAM) ? r_mem[r_idx] : '0;
  assign bus.s_rst_last_o   = (r_state == ST_STREAM) && (r_rem == CNT_ONE);
  assign bus.s_rst_done_o   = r_done;
  assign bus.s_depth_o      = r_cnt;
endmodule

// File: tb/tb_ras_commit_stack.sv
// Self-checking bench: queue-based stack model compared every cycle, directed
// scenarios with literal expectations, then randomized commit/restore traffic.
module tb_ras_commit_stack;
  localparam int SIZE  = 4;
  localparam int WIDTH = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ras_commit_stack_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

  ras_commit_stack #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .s_clk_i  (clk),
    .s_reset_i(rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue holds live entries oldest first; a restore pass is just a read position.
  logic [WIDTH-1:0] m_q[$];
  bit m_stream = 1'b0;
  int m_pos    = 0;
  bit m_mis    = 1'b0;
  bit m_done   = 1'b0;
  bit m_armed  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_stream = 1'b0;
      m_pos    = 0;
      m_mis    = 1'b0;
      m_done   = 1'b0;
      m_armed  = 1'b1;
    end else if (m_armed) begin
      if (m_stream) check("no_commit_in_stream", 64'(bus.s_commit_i), 64'd0);
      m_mis  = bus.s_commit_i && bus.s_pop_i && bus.s_predicted_i &&
               (bus.s_pred_addr_i != bus.s_target_i);
      m_done = 1'b0;
      if (!m_stream) begin
        if (bus.s_commit_i) begin
          if (bus.s_push_i && (!bus.s_pop_i || m_q.size() == 0)) begin
            if (m_q.size() == SIZE) void'(m_q.pop_front());
            m_q.push_back(bus.s_link_addr_i);
          end else if (bus.s_push_i) begin
            m_q[m_q.size()-1] = bus.s_link_addr_i;
          end else if (bus.s_pop_i && m_q.size() > 0) begin
            void'(m_q.pop_back());
          end
        end
        if (bus.s_restore_i) begin
          if (m_q.size() == 0) m_done = 1'b1;
          else begin
            m_stream = 1'b1;
            m_pos    = 0;
          end
        end
      end else if (bus.s_restore_i) begin
        m_pos = 0;
      end else if (bus.s_rst_ready_i) begin
        if (m_pos == m_q.size() - 1) begin
          m_stream = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("depth", 64'(bus.s_depth_o), 64'(m_q.size()));
      check("busy", 64'(bus.s_busy_o), 64'(m_stream));
      check("valid", 64'(bus.s_rst_valid_o), 64'(m_stream));
      check("mispredict", 64'(bus.s_mispredict_o), 64'(m_mis));
      check("done", 64'(bus.s_rst_done_o), 64'(m_done));
      check("last", 64'(bus.s_rst_last_o), 64'(m_stream && (m_pos == m_q.size() - 1)));
      check("data", 64'(bus.s_rst_data_o), m_stream ? 64'(m_q[m_pos]) : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.s_commit_i    = 1'b0;
    bus.s_push_i      = 1'b0;
    bus.s_pop_i       = 1'b0;
    bus.s_link_addr_i = '0;
    bus.s_target_i    = '0;
    bus.s_predicted_i = 1'b0;
    bus.s_pred_addr_i = '0;
    bus.s_restore_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic commit_op(input bit push, input bit pop, input logic [WIDTH-1:0] link,
                           input logic [WIDTH-1:0] tgt, input bit pred,
                           input logic [WIDTH-1:0] pa);
    bus.s_commit_i    = 1'b1;
    bus.s_push_i      = push;
    bus.s_pop_i       = pop;
    bus.s_link_addr_i = link;
    bus.s_target_i    = tgt;
    bus.s_predicted_i = pred;
    bus.s_pred_addr_i = pa;
    tick();
    clear_in();
  endtask

  task automatic push(input logic [WIDTH-1:0] link);
    commit_op(1'b1, 1'b0, link, '0, 1'b0, '0);
  endtask

  task automatic restore_pulse();
    bus.s_restore_i = 1'b1;
    tick();
    bus.s_restore_i = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_stream[4];
  int r;

  initial begin
    clear_in();
    bus.s_rst_ready_i = 1'b1;
    do_reset();
    check("reset_depth", 64'(bus.s_depth_o), 64'd0);
    check("reset_valid", 64'(bus.s_rst_valid_o), 64'd0);
    check("reset_done", 64'(bus.s_rst_done_o), 64'd0);
    check("reset_busy", 64'(bus.s_busy_o), 64'd0);

    // Basic push/pop with a correct prediction.
    push(31'h100); push(31'h200); push(31'h300);
    check("t1_depth3", 64'(bus.s_depth_o), 64'd3);
    commit_op(1'b0, 1'b1, '0, 31'h300, 1'b1, 31'h300);
    check("t1_depth2", 64'(bus.s_depth_o), 64'd2);
    check("t1_no_mis", 64'(bus.s_mispredict_o), 64'd0);

    // Wrong predicted target pulses mispredict for exactly one cycle.
    do_reset();
    push(31'h40);
    commit_op(1'b0, 1'b1, '0, 31'h40, 1'b1, 31'h44);
    check("t2_mis", 64'(bus.s_mispredict_o), 64'd1);
    check("t2_depth0", 64'(bus.s_depth_o), 64'd0);
    tick();
    check("t2_mis_gone", 64'(bus.s_mispredict_o), 64'd0);

    // Overflow keeps the newest SIZE entries; full restore with ready high.
    do_reset();
    for (int i = 1; i <= 6; i++) push(WIDTH'(i));
    check("t3_depth4", 64'(bus.s_depth_o), 64'd4);
    exp_stream[0] = 31'h3; exp_stream[1] = 31'h4;
    exp_stream[2] = 31'h5; exp_stream[3] = 31'h6;
    restore_pulse();
    for (int i = 0; i < 4; i++) begin
      check("t3_valid", 64'(bus.s_rst_valid_o), 64'd1);
      check("t3_data", 64'(bus.s_rst_data_o), 64'(exp_stream[i]));
      check("t3_last", 64'(bus.s_rst_last_o), 64'(i == 3));
      tick();
    end
    check("t3_done", 64'(bus.s_rst_done_o), 64'd1);
    check("t3_valid_off", 64'(bus.s_rst_valid_o), 64'd0);
    tick();
    check("t3_done_pulse", 64'(bus.s_rst_done_o), 64'd0);

    // Backpressure on the second entry: data held, done after 5 valid cycles.
    do_reset();
    push(31'hA); push(31'hB); push(31'hC);
    restore_pulse();
    check("t4_d0", 64'(bus.s_rst_data_o), 64'hA);
    tick();
    check("t4_d1", 64'(bus.s_rst_data_o), 64'hB);
    bus.s_rst_ready_i = 1'b0;
    tick();
    check("t4_hold1", 64'(bus.s_rst_data_o), 64'hB);
    tick();
    check("t4_hold2", 64'(bus.s_rst_data_o), 64'hB);
    check("t4_hold_last", 64'(bus.s_rst_last_o), 64'd0);
    bus.s_rst_ready_i = 1'b1;
    tick();
    check("t4_d2", 64'(bus.s_rst_data_o), 64'hC);
    check("t4_last", 64'(bus.s_rst_last_o), 64'd1);
    tick();
    check("t4_done", 64'(bus.s_rst_done_o), 64'd1);

    // Coroutine swap overwrites the top; swap on empty acts as push.
    do_reset();
    push(31'h10); push(31'h20);
    commit_op(1'b1, 1'b1, 31'h77, 31'h20, 1'b0, '0);
    check("t5_depth2", 64'(bus.s_depth_o), 64'd2);
    restore_pulse();
    check("t5_old", 64'(bus.s_rst_data_o), 64'h10);
    tick();
    check("t5_top", 64'(bus.s_rst_data_o), 64'h77);
    check("t5_last", 64'(bus.s_rst_last_o), 64'd1);
    tick();
    do_reset();
    commit_op(1'b1, 1'b1, 31'h55, '0, 1'b0, '0);
    check("t5_empty_swap", 64'(bus.s_depth_o), 64'd1);

    // Reset mid-stream, then restore of an empty stack.
    do_reset();
    push(31'h1); push(31'h2); push(31'h3);
    restore_pulse();
    tick();
    rst = 1'b1;
    tick();
    check("t6_valid", 64'(bus.s_rst_valid_o), 64'd0);
    check("t6_depth", 64'(bus.s_depth_o), 64'd0);
    check("t6_no_done", 64'(bus.s_rst_done_o), 64'd0);
    rst = 1'b0;
    tick();
    check("t6_no_done2", 64'(bus.s_rst_done_o), 64'd0);
    restore_pulse();
    check("t6_empty_done", 64'(bus.s_rst_done_o), 64'd1);
    check("t6_empty_valid", 64'(bus.s_rst_valid_o), 64'd0);
    tick();
    check("t6_empty_done_pulse", 64'(bus.s_rst_done_o), 64'd0);

    // Randomized traffic; commits only issued while the model is idle.
    for (int c = 0; c < 3000; c++) begin
      clear_in();
      rst = ($urandom_range(0, 299) == 0);
      bus.s_rst_ready_i = ($urandom_range(0, 3) != 0);
      if (!m_stream) begin
        bus.s_commit_i = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 9);
        bus.s_push_i      = (r <= 4) || (r == 8);
        bus.s_pop_i       = (r >= 5 && r <= 8);
        bus.s_link_addr_i = WIDTH'($urandom);
        bus.s_target_i    = WIDTH'($urandom_range(0, 255));
        bus.s_predicted_i = $urandom_range(0, 1) == 1;
        bus.s_pred_addr_i = ($urandom_range(0, 1) == 1) ? bus.s_target_i
                                                         : WIDTH'($urandom_range(0, 255));
        bus.s_restore_i   = ($urandom_range(0, 9) == 0);
      end else begin
        bus.s_restore_i = ($urandom_range(0, 19) == 0);
      end
      tick();
    end
    clear_in();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
